// File: rtl/mult_seq_ctrl.sv
// Sequencer and stall controller for the multi-cycle multiplier: launch, HI/LO capture, watchdog.
// Optional feature macro MULT_OVERLAP_EN: stall only on hazards in BUSY and allow back-to-back multiplies.
module mult_seq_ctrl #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        mult_reqE,
    input  logic        mf_reqD,
    input  logic        mult_doneX,
    input  logic [63:0] mult_resultX,
    output logic        mult_start,
    output logic        pipe_nEN,
    output logic        mult_finish,
    output logic        busy,
    output logic        fault,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          mult_start_q, mult_start_d;
    logic          mult_finish_q, mult_finish_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          pipe_hold;
    logic          accept;

`ifdef MULT_OVERLAP_EN
    // Independent instructions keep flowing; only an MF read or a second
    // multiply in flight behind the busy unit has to wait.
    always_comb begin
        pipe_hold = (state_q == S_FAULT) ||
                    ((state_q == S_BUSY) && (mf_reqD || mult_reqE));
        accept    = mult_reqE && !pipe_hold &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
    end
`else
    logic unused_mf_reqD;
    assign unused_mf_reqD = mf_reqD;

    always_comb begin
        pipe_hold = (state_q != S_IDLE);
        accept    = mult_reqE && !pipe_hold && (state_q == S_IDLE);
    end
`endif

    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = wd_cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mult_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_BUSY;
                    mult_start_d = 1'b1;
                    wd_cnt_d     = '0;
                end
            end
            S_BUSY: begin
                // Completion takes priority over an expiring watchdog.
                if (mult_doneX) begin
                    hi_d    = mult_resultX[63:32];
                    lo_d    = mult_resultX[31:0];
                    state_d = S_DONE;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_ONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_d      = S_BUSY;
                    mult_start_d = 1'b1;
                    wd_cnt_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state, so they
        // line up with state_q and never glitch.
        mult_finish_d = (state_d == S_DONE);
        busy_d        = (state_d == S_BUSY) || (state_d == S_DONE);
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wd_cnt_q      <= '0;
            mult_start_q  <= 1'b0;
            mult_finish_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            wd_cnt_q      <= wd_cnt_d;
            mult_start_q  <= mult_start_d;
            mult_finish_q <= mult_finish_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
        end
    end

    assign pipe_nEN    = pipe_hold;
    assign mult_start  = mult_start_q;
    assign mult_finish = mult_finish_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencer for the multi-cycle multiplier and its interaction with the five-stage pipeline. It launches the multiplier when a MULT/MULTU leaves Execute and tracks the operation to completion. It captures the 64-bit product into HI/LO, pulses `mult_finish` toward Memory, and drives the common active-low enable `pipe_nEN` into the F/D, D/E, E/M and M/W pipeline registers to stall the pipeline while the result is pending. A watchdog traps a multiplier that never signals completion.

## Interface
Parameters:
- `TIMEOUT`, 40: maximum BUSY cycles before FAULT; legal range 2..255.
- `CW`, 8: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `mult_reqE` in 1: MULT/MULTU valid in Execute.
- `mf_reqD` in 1: MFHI/MFLO valid in Decode.
- `mult_doneX` in 1: multiplier completion strobe; 1-cycle pulse.
- `mult_resultX` in 64: product; valid when `mult_doneX`=1.
- `mult_start` out 1: 1-cycle launch pulse to the multiplier.
- `pipe_nEN` out 1: pipeline-register enable; 0 = advance, 1 = hold.
- `mult_finish` out 1: 1-cycle pulse, the cycle HI/LO become valid.
- `busy` out 1: state is BUSY or DONE.
- `fault` out 1: sticky watchdog trap.
- `HI` out 32: product bits [63:32].
- `LO` out 32: product bits [31:0].

## Operation
States: IDLE, BUSY, DONE, FAULT. Reset state is IDLE.

Reset values: `mult_start`=0, `pipe_nEN`=0, `mult_finish`=0, `busy`=0, `fault`=0, `HI`=0, `LO`=0, watchdog count=0.

- **accept** = `mult_reqE` & !`pipe_nEN` & (state==IDLE | (state==DONE & overlap enabled)). A request is only taken while the E-stage instruction is actually advancing.
- **IDLE**, on accept: go to BUSY, register `mult_start`=1 for the first BUSY cycle, clear the count. Otherwise stay in IDLE.
- **BUSY**, on `mult_doneX`:
  - capture `HI`<=`mult_resultX`[63:32] and `LO`<=`mult_resultX`[31:0];
  - go to DONE.
- **BUSY** otherwise: count+1. If the count reaches TIMEOUT-1 with no done, go to FAULT.
- **BUSY**, `mult_doneX` and timeout in the same cycle: done wins.
- **DONE**: `mult_finish`=1 for exactly this cycle. Go to BUSY on accept (back-to-back, new `mult_start`), else go to IDLE.
- **FAULT**: absorbing; `fault`=1 and `pipe_nEN`=1 until `reset`.
- `mult_doneX` outside BUSY is ignored; HI/LO are unchanged.
- `mult_resultX` is only sampled on done-in-BUSY.
- `pipe_nEN` is combinational from state and request inputs (see Configuration). `mult_start` and `mult_finish` are registered or decoded from state, glitch-free.

## Timing
- A request in cycle t (accepted) gives BUSY and `mult_start`=1 at t+1.
- Done at cycle d gives DONE, `mult_finish`=1 and new HI/LO visible at d+1, then IDLE at d+2.
- Minimum request-to-finish latency is 2 cycles (done in the first BUSY cycle).
- An MFHI/MFLO held in D by the stall reads HI/LO in E no earlier than the cycle after DONE, so it always sees the new product.
- `reset` low mid-operation: every output takes its reset value asynchronously. A done pulse arriving afterwards is ignored.

## Configuration
- `MULT_OVERLAP_EN` undefined:
  - `pipe_nEN`=1 in BUSY, DONE and FAULT, so the pipeline freezes for the whole multiply;
  - no accept in DONE.
- `MULT_OVERLAP_EN` defined:
  - `pipe_nEN`=1 only in FAULT, or in BUSY when (`mf_reqD` | `mult_reqE`); independent instructions keep flowing;
  - accept in DONE is allowed (back-to-back multiplies).

## Test plan
- **Basic multiply:** reset, then `mult_reqE` for 1 cycle, done 5 cycles later with result 0x0000_0001_8000_0000 -> `mult_start` pulses once; `HI`=0x00000001 and `LO`=0x80000000 in the `mult_finish` cycle; `pipe_nEN`=1 for 6 cycles when non-overlap; back to IDLE.
- **Overlap hazard:** with `MULT_OVERLAP_EN`, request, then `mf_reqD`=1 from BUSY cycle 2 -> `pipe_nEN`=0 in BUSY cycle 1 and 1 from cycle 2 until done; 0 in the DONE cycle.
- **Back-to-back:** with overlap, second `mult_reqE` held through BUSY -> accepted in DONE; `mult_start` reissued the next cycle; each `mult_finish` matches its own product.
- **Watchdog:** TIMEOUT=4, request, no done -> FAULT after 4 BUSY cycles; `fault`=1 and `pipe_nEN`=1 held; a late `mult_doneX` leaves HI/LO at their previous values.
- **Mid-op reset:** drop `reset` in BUSY cycle 2 -> all outputs 0 immediately; a done pulse after release does not change HI/LO.
- **Stray done:** `mult_doneX`=1 in IDLE with result 0xFFFF_FFFF_FFFF_FFFF -> HI/LO stay 0; no `mult_finish`.
